// File: rtl/image_stream_pkg.sv
// rtl/image_stream_pkg.sv - shared types and constants for the pixel stream sink
package image_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_t;

    localparam int ERR_NO_SOF    = 0;
    localparam int ERR_EARLY_EOL = 1;
    localparam int ERR_LATE_EOL  = 2;
    localparam int ERR_MID_SOF   = 3;

    localparam int SUM_BITWIDTH  = 32;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - column/row position tracker for one raster frame
module raster_counter #(
    parameter int WIDTH  = -1,
    parameter int HEIGHT = -1,
    localparam int COL_BITS = (WIDTH > 2) ? $clog2(WIDTH) : 1,
    localparam int ROW_BITS = (HEIGHT > 2) ? $clog2(HEIGHT) : 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                advance,
    input  logic                restart,
    input  logic                force_eol,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] row,
    output logic                line_end,
    output logic                frame_end
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT - 1);

    // A restart beat is pixel (0,0), so only an explicit tlast can end its line.
    assign line_end  = restart ? force_eol : (force_eol | (col == LAST_COL));
    assign frame_end = !restart & line_end & (row == LAST_ROW);

    // Position update per accepted pixel; wraps to (0,0) after the last line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (restart) begin
                col <= force_eol ? COL_BITS'(0) : COL_BITS'(1);
                row <= force_eol ? ROW_BITS'(1) : ROW_BITS'(0);
            end else if (frame_end) begin
                col <= '0;
                row <= '0;
            end else if (line_end) begin
                col <= '0;
                row <= row + ROW_BITS'(1);
            end else begin
                col <= col + COL_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/image_receiver.sv
// rtl/image_receiver.sv - raster frame sink with checksum, frame count and sticky error flags
module image_receiver
    import image_stream_pkg::*;
#(
    parameter int WIDTH          = -1,
    parameter int HEIGHT         = -1,
    parameter int PIXEL_BITWIDTH = 24
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [PIXEL_BITWIDTH-1:0] i_axis_tdata,
    input  logic                      i_axis_tlast,
    input  logic                      i_axis_tuser,
    input  logic                      i_axis_tvalid,
    output logic                      o_axis_ready,
    input  logic                      i_ready_en,
    input  logic                      i_clear,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic [SUM_BITWIDTH-1:0]   o_frame_sum,
    output logic [15:0]               o_frame_count,
    output logic [3:0]                o_err
);

    localparam int COL_BITS = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int ROW_BITS = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);

    rx_state_t               state;
    logic [SUM_BITWIDTH-1:0] sum;
    logic [SUM_BITWIDTH-1:0] pixel;
    logic [SUM_BITWIDTH-1:0] sum_next;
    logic [COL_BITS-1:0]     col;
    logic [ROW_BITS-1:0]     row;
    logic                    line_end;
    logic                    frame_end;
    logic                    beat;
    logic                    advance;
    logic [3:0]              err_set;

    // Ready is held low during reset and for the single DONE cycle.
    assign o_axis_ready = n_rst & i_ready_en & (state != DONE);
    assign o_busy       = (state == RECV);
    assign beat         = i_axis_tvalid & o_axis_ready;
    assign advance      = beat & (((state == IDLE) & i_axis_tuser) | (state == RECV));

    assign pixel        = SUM_BITWIDTH'(i_axis_tdata);
    assign sum_next     = ((state == RECV) && !i_axis_tuser) ? sum + pixel : pixel;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk       (clk),
        .n_rst     (n_rst),
        .advance   (advance),
        .restart   (i_axis_tuser),
        .force_eol (i_axis_tlast),
        .col       (col),
        .row       (row),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Protocol violations detected on the current beat.
    always_comb begin
        err_set                = '0;
        err_set[ERR_NO_SOF]    = beat & (state == IDLE) & !i_axis_tuser;
        err_set[ERR_EARLY_EOL] = advance & i_axis_tlast & (i_axis_tuser | (col != LAST_COL));
        err_set[ERR_LATE_EOL]  = advance & !i_axis_tuser & !i_axis_tlast & (col == LAST_COL);
        err_set[ERR_MID_SOF]   = beat & (state == RECV) & i_axis_tuser;
    end

    // Frame FSM with checksum, completion reporting and sticky error flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            sum           <= '0;
            o_frame_done  <= 1'b0;
            o_frame_sum   <= '0;
            o_frame_count <= '0;
            o_err         <= '0;
        end else begin
            o_err        <= (i_clear ? 4'b0 : o_err) | err_set;
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat && i_axis_tuser) begin
                        sum   <= pixel;
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (beat) begin
                        sum <= sum_next;
                        if (frame_end) begin
                            state         <= DONE;
                            o_frame_done  <= 1'b1;
                            o_frame_sum   <= sum_next;
                            o_frame_count <= o_frame_count + 16'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Between frames the raster position must be parked at (0,0).
    assert property (@(posedge clk) disable iff (!n_rst)
        (state != IDLE) || ((col == '0) && (row == '0)));

    // The raster tracker reports line ends to the FSM only through frame_end.
    logic unused_line_end;
    assign unused_line_end = line_end;

endmodule

// File: tb/tb_image_receiver.sv
// tb/tb_image_receiver.sv - scoreboard bench for image_receiver on 8x8 frames
module tb_image_receiver;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PB = 24;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [PB-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic          tuser = 1'b0;
    logic          tvalid = 1'b0;
    logic          ready_en = 1'b1;
    logic          clear = 1'b0;
    logic          o_axis_ready;
    logic          o_busy;
    logic          o_frame_done;
    logic [31:0]   o_frame_sum;
    logic [15:0]   o_frame_count;
    logic [3:0]    o_err;

    image_receiver #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .PIXEL_BITWIDTH (PB)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .i_axis_tdata  (tdata),
        .i_axis_tlast  (tlast),
        .i_axis_tuser  (tuser),
        .i_axis_tvalid (tvalid),
        .o_axis_ready  (o_axis_ready),
        .i_ready_en    (ready_en),
        .i_clear       (clear),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_frame_sum   (o_frame_sum),
        .o_frame_count (o_frame_count),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] count;
        logic [3:0]  err;
        int          beats;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          beats_since_sof = 0;
    logic [15:0] exp_count = '0;
    bit          stall = 1'b0;
    bit          prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [PB-1:0] quad(input int r, input int c);
        if (r < 4 && c < 4) return 24'hFF0000;
        if (r < 4)          return 24'h00FF00;
        if (c < 4)          return 24'h0000FF;
        return 24'hFFFFFF;
    endfunction

    task automatic expect_frame(input logic [31:0] sum, input logic [3:0] err, input int beats);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.sum   = sum;
        e.count = exp_count;
        e.err   = err;
        e.beats = beats;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send_beat(input logic [PB-1:0] d, input logic last, input logic user);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        tdata  = d;
        tlast  = last;
        tuser  = user;
        tvalid = 1'b1;
        do begin
            if (stall) ready_en = ~ready_en;
            #1 ok = o_axis_ready;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end while (!ok && guard < 50);
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
        else if (user) beats_since_sof = 1;
        else beats_since_sof++;
    endtask

    task automatic send_frame(input int early_row, input int late_row);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == early_row && c > 5) continue;
                send_beat(quad(r, c),
                          (c == 7 && r != late_row) || (r == early_row && c == 5),
                          (r == 0 && c == 0));
            end
        end
        tvalid   = 1'b0;
        ready_en = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_done_timeout: got %0d pending required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_and_check(input string name);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check(name, {28'd0, o_err}, 32'd0);
    endtask

    // Monitor: pops one expectation per done pulse and compares the reported frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (n_rst && o_frame_done) begin
                check("done_single_pulse", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_sum", o_frame_sum, e.sum);
                    check("frame_count", {16'd0, o_frame_count}, {16'd0, e.count});
                    check("frame_err", {28'd0, o_err}, {28'd0, e.err});
                    check("ready_low_at_done", {31'd0, o_axis_ready}, 32'd0);
                    check("beats_to_done", beats_since_sof, e.beats);
                end
            end
            prev_done = n_rst && o_frame_done;
        end
    end

    initial begin
        @(negedge clk);
        #1;
        check("rst_ready", {31'd0, o_axis_ready}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_frame_done}, 32'd0);
        check("rst_sum", o_frame_sum, 32'd0);
        check("rst_count", {16'd0, o_frame_count}, 32'd0);
        check("rst_err", {28'd0, o_err}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        expect_frame(32'h1FFFFFE0, 4'b0000, 64);
        send_frame(-1, -1);
        wait_done("clean");

        stall = 1'b1;
        expect_frame(32'h1FFFFFE0, 4'b0000, 64);
        send_frame(-1, -1);
        stall = 1'b0;
        wait_done("stall");

        expect_frame(32'h1FFFFFE0, 4'b0001, 64);
        for (int i = 0; i < 3; i++) send_beat(24'hABCDEF, 1'b0, 1'b0);
        send_frame(-1, -1);
        wait_done("no_sof");
        clear_and_check("clear_no_sof");

        expect_frame(32'h1FFE01E0, 4'b0010, 62);
        send_frame(2, -1);
        wait_done("early_eol");
        clear_and_check("clear_early_eol");

        expect_frame(32'h1FFFFFE0, 4'b0100, 64);
        send_frame(-1, 4);
        wait_done("late_eol");
        clear_and_check("clear_late_eol");

        expect_frame(32'h1FFFFFE0, 4'b1000, 64);
        for (int i = 0; i < 28; i++) send_beat(24'h123456, (i % 8) == 7, i == 0);
        send_frame(-1, -1);
        wait_done("mid_sof");
        clear_and_check("clear_mid_sof");

        for (int i = 0; i < 30; i++) send_beat(quad(i / 8, i % 8), (i % 8) == 7, i == 0);
        n_rst  = 1'b0;
        tvalid = 1'b0;
        #1;
        check("midrst_ready", {31'd0, o_axis_ready}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_done", {31'd0, o_frame_done}, 32'd0);
        check("midrst_sum", o_frame_sum, 32'd0);
        check("midrst_count", {16'd0, o_frame_count}, 32'd0);
        check("midrst_err", {28'd0, o_err}, 32'd0);
        exp_count = '0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        expect_frame(32'h1FFFFFE0, 4'b0000, 64);
        send_frame(-1, -1);
        wait_done("after_reset");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
# image_receiver

AXI4-Stream video sink that accepts a raster frame (tuser on the first pixel, tlast at the end of each line) from a pixel source such as the test-pattern generator. It checks the frame structure, accumulates a 32-bit pixel checksum, and reports per-frame completion with sticky protocol-error flags. It sits at the consuming end of the pixel stream, either in front of the JPEG block pipeline or as a bench and loopback checker.

## Interface
Parameters:
- WIDTH, -1 (must be set, ≥2): pixels per line
- HEIGHT, -1 (must be set, ≥2): lines per frame
- PIXEL_BITWIDTH, 24: tdata width, at most 32

Ports:
- clk  input  1  single clock, all logic on its rising edge
- n_rst  input  1  reset, asynchronous, active-low
- i_axis_tdata  input  PIXEL_BITWIDTH  pixel data
- i_axis_tlast  input  1  end of line
- i_axis_tuser  input  1  start of frame
- i_axis_tvalid  input  1  beat valid
- o_axis_ready  output  1  sink ready
- i_ready_en  input  1  backpressure control; 0 forces ready low
- i_clear  input  1  clears the sticky error flags
- o_busy  output  1  frame in progress
- o_frame_done  output  1  one-cycle pulse after the last beat of a frame
- o_frame_sum  output  32  checksum of the last completed frame
- o_frame_count  output  16  number of completed frames, wraps
- o_err  output  4  sticky flags: [0] NO_SOF, [1] EARLY_EOL, [2] LATE_EOL, [3] MID_SOF

## Operation
- Beat: a transfer occurs only when i_axis_tvalid & o_axis_ready. Nothing is sampled otherwise.
- o_axis_ready = i_ready_en & (state != DONE). It is combinational from registered state.
- State machine: IDLE, RECV, DONE.
- IDLE:
  - A beat with tuser=1 becomes pixel (0,0). Set col=1 (or col=0, row=1 if it also ends the line), sum=tdata, then go to RECV.
  - A beat with tuser=0 is dropped and sets err[0].
- RECV: for each beat, sum += zero-extended tdata, modulo 2^32.
  - Line end is the earlier of: tlast=1, or col==WIDTH-1.
  - tlast with col<WIDTH-1 sets err[1].
  - col==WIDTH-1 with tlast=0 sets err[2].
  - At line end: col←0, row←row+1.
  - tuser=1 in RECV sets err[3]. The frame restarts with this beat as pixel (0,0), and sum=tdata.
  - Line end with row==HEIGHT-1 goes to DONE.
- DONE lasts exactly one cycle and then returns to IDLE:
  - o_frame_done=1.
  - o_frame_sum ← final sum, including the last beat.
  - o_frame_count increments.
  - Ready is low.
- o_err bits set and hold until i_clear. If i_clear and a new error occur in the same cycle, the bit is set (the set wins).
- o_busy = (state == RECV).

## Timing
- Reset values: state IDLE, col/row/sum 0, o_frame_done 0, o_frame_sum 0, o_frame_count 0, o_err 0, o_busy 0. o_axis_ready is 0 while n_rst=0.
- Asserting n_rst mid-frame abandons the frame immediately: no done pulse, counters zeroed.
- Last beat accepted at cycle N: o_frame_done=1 and the new o_frame_sum is visible in cycle N+1. Ready is low in N+1 and returns in N+2.
- Throughput is one pixel per cycle inside a frame. A frame costs WIDTH·HEIGHT beats + 1 dead cycle.
- Counters: col is $clog2(WIDTH) bits and row is $clog2(HEIGHT) bits. Neither exceeds its maximum. sum is 32 bits and wraps.
- Deasserting i_ready_en mid-frame stalls without any state change. Data held by the source must not be double-counted.

## Structure
- Shared package image_stream_pkg:
  - state enum rx_state_t {IDLE, RECV, DONE}
  - error index constants ERR_NO_SOF=0, ERR_EARLY_EOL=1, ERR_LATE_EOL=2, ERR_MID_SOF=3
  - checksum width constant SUM_BITWIDTH=32
- One sub-module: raster_counter (WIDTH, HEIGHT). It holds col/row and takes inputs advance, restart, and force_eol. Its outputs are col, row, line_end, and frame_end.
- The FSM, checksum, and error logic stay in image_receiver.

## Test plan
- WIDTH=HEIGHT=8, quadrant pattern with 16 px each of FF0000/00FF00/0000FF/FFFFFF, tlast every 8th beat, i_ready_en=1 → one o_frame_done pulse, o_frame_sum=0x1FFFFFE0, o_frame_count=1, o_err=0.
- Same frame with i_ready_en toggled 1-0-1-0 and tvalid held during stalls → identical sum, count, and flags. The done pulse arrives later but is still a single pulse.
- Three beats with tuser=0 before the SOF → err[0]=1, frame still completes with the same sum. i_clear → o_err=0.
- tlast on col 5 of row 2 → err[1]=1, row advances, frame completes after 8 line ends. Omitting tlast on col 7 → err[2]=1.
- tuser on row 3 col 4 → err[3]=1, counting restarts, done pulse comes 64 beats after the second SOF.
- Assert n_rst at beat 30 of a frame → all outputs return to reset values, no done pulse. The following clean frame gives sum 0x1FFFFFE0, count 1.
